m68k_bus_responder: RTL and testbench
=====================================

# m68k_bus_responder

68000-bus target (slave) that answers bus cycles driven by the PiStorm bus-master logic on the motherboard side. It decodes the 24-bit address, serves a 512-byte on-chip RAM window with programmable DTACK wait states, and requests a 6800-style cycle via VPA for a peripheral window and for interrupt acknowledge (autovector). It signals bus error on unmapped accesses after a timeout. It is used as a bench/loopback target and as the motherboard-less bring-up target for the bridge.

## Interface
Parameters:
- RAM_BASE, 15'h0000: compared to M68K_A[23:9]; a match selects the RAM window.
- VPA_BASE, 8'hBF: compared to M68K_A[23:16]; a match selects the VPA window.
- WAIT_STATES, 1: extra M68K_CLK cycles before DTACK. Range 0–15.
- BERR_TIMEOUT, 64: cycles of unanswered AS before BERR. Range 2–255.

Ports (clock and reset first):
- M68K_CLK  in  1  single clock; all logic on the rising edge.
- M68K_RESET_n  in  1  asynchronous, active-low reset.
- M68K_A  in  23  address bits A[23:1].
- M68K_FC  in  3  function code; 3'b111 means interrupt acknowledge.
- M68K_AS_n  in  1  address strobe.
- M68K_UDS_n, M68K_LDS_n  in  1 each  upper and lower data strobes.
- M68K_RW  in  1  1 = read, 0 = write.
- M68K_D_IN  in  16  write data from the initiator.
- M68K_D_OUT  out  16  read data.
- M68K_D_OE  out  1  read-data drive enable.
- M68K_DTACK_n  out  1  data acknowledge.
- M68K_BERR_n  out  1  bus error.
- M68K_VPA_n  out  1  valid peripheral address.

## Operation
- Input registering: AS_n, UDS_n, LDS_n, RW and D_IN are registered once (as_q, uds_q, lds_q, rw_q, d_q). A, FC and RW are captured on the cycle start edge.
- Reset values: DTACK_n=1, BERR_n=1, VPA_n=1, D_OE=0, D_OUT=0, state=IDLE. RAM contents are not reset.
- States:
  - IDLE: when as_q=0, capture address, FC and RW; classify the cycle as RAM, VPA (VPA window or FC=111) or UNMAPPED; load the counter (WAIT_STATES for RAM, BERR_TIMEOUT for UNMAPPED); go to WAIT.
  - WAIT, RAM cycle: decrement the counter. At 0:
    - Read: drive D_OUT from RAM, set D_OE=1 and DTACK_n=0, go to ACK.
    - Write: needs uds_q=0 or lds_q=0. Write only the asserted byte lanes from d_q (UDS→[15:8], LDS→[7:0]), set DTACK_n=0, go to ACK. If both strobes are still high, stay in WAIT with the counter held at 0.
  - WAIT, VPA cycle: set VPA_n=0 on the first WAIT edge, go to ACK. DTACK is never asserted. Reads drive D_OUT=16'h0000 with D_OE=1.
  - WAIT, UNMAPPED cycle: decrement the counter. At 0, set BERR_n=0 and go to ACK.
  - ACK: hold all outputs until as_q=1.
  - Release (any non-IDLE state with as_q=1): on that edge set DTACK_n, BERR_n and VPA_n to 1 and D_OE to 0; go to IDLE. This includes AS aborting during WAIT; no RAM write occurs unless DTACK was already issued.
- Back-to-back cycles: AS low again on the first IDLE edge starts a new cycle with no dead cycle.
- Reset asserted mid-cycle: all outputs take their reset values immediately (asynchronous).

## Timing
- t0 is the first edge at which as_q=0 (decode edge). The RAM read address is presented at t0; RAM read latency is 1 cycle.
- RAM cycle: DTACK_n falls at edge t0+1+WAIT_STATES. For reads, D_OE and D_OUT change on the same edge.
- VPA cycle: VPA_n falls at t0+1.
- UNMAPPED cycle: BERR_n falls at t0+1+BERR_TIMEOUT.
- Release: outputs deassert at the edge after the first edge with as_q=1, i.e. two edges after AS_n rises.
- All outputs are registered and glitch-free.

## Structure
- Package m68k_bus_pkg holds:
  - state enum {IDLE, WAIT, ACK};
  - cycle-class enum {CYC_RAM, CYC_VPA, CYC_UNMAPPED};
  - localparam FC_IACK = 3'b111.
- Sub-module responder_ram: 256×16, synchronous read, byte-lane write enables, address A[8:1].
- Counter is 8 bits. WAIT_STATES and BERR_TIMEOUT are zero-extended into it.

## Test plan
- Read, WAIT_STATES=1: preload RAM[0x10]=16'hBEEF; read A=RAM_BASE<<9 | 0x20 → DTACK_n low at t0+2, D_OUT=BEEF, D_OE=1; both drop 2 edges after AS_n rises.
- Byte write: UDS only, D_IN=16'h12FF to word 0x10 holding BEEF → RAM=12EF. With UDS asserted one cycle after AS and WAIT_STATES=0, DTACK is delayed until the strobe is seen.
- IACK: FC=111, AS low → VPA_n low at t0+1, DTACK_n stays 1, VPA released after AS rises.
- Unmapped read, BERR_TIMEOUT=8 → BERR_n low at t0+9, no DTACK; abort with AS rising at t0+4 → BERR never asserts.
- Reset mid-ACK: assert M68K_RESET_n=0 while DTACK_n=0 → DTACK_n=1 and D_OE=0 immediately; the next cycle after reset completes normally.
- Back-to-back reads of 0x0000 and 0x01FE with AS high for one cycle → two correct DTACKs with correct data.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000 bus responder: FSM states, cycle classes and
// the function code that marks an interrupt-acknowledge cycle.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    CYC_RAM,
    CYC_VPA,
    CYC_UNMAPPED
  } cyc_e;

  localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/m68k_bus_responder_ram.sv
// 256 x 16 on-chip RAM behind the responder: synchronous read, byte-lane writes.
module responder_ram (
  input  logic        clk_i,
  input  logic [7:0]  addr_i,
  input  logic        we_hi_i,
  input  logic        we_lo_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);

  logic [15:0] mem_q [256];
  logic [15:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_hi_i) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_lo_i) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: 512-byte RAM window with DTACK wait states, VPA window and
// autovector IACK, bus error on unmapped cycles after a timeout.
//
// state | meaning
// IDLE  | waiting for AS; decode and classify on the first edge AS is seen low
// WAIT  | counting wait states / timeout, or waiting for a write data strobe
// ACK   | DTACK, VPA or BERR asserted and held until AS is released
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [14:0] RAM_BASE     = 15'h0000,
  parameter logic [7:0]  VPA_BASE     = 8'hBF,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        M68K_VPA_n
);

  localparam logic [7:0] WS_LOAD = 8'(WAIT_STATES);
  localparam logic [7:0] BT_LOAD = 8'(BERR_TIMEOUT);

  logic        as_q, uds_q, lds_q, rw_q;
  logic [15:0] d_q;

  state_e      state_q, state_d;
  cyc_e        cls_q, cls_d;
  logic [7:0]  addr_q, addr_d;
  logic        rwc_q, rwc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dtack_n_q, dtack_n_d;
  logic        berr_n_q, berr_n_d;
  logic        vpa_n_q, vpa_n_d;
  logic        doe_q, doe_d;
  logic [15:0] dout_q, dout_d;

  logic [7:0]  ram_addr;
  logic        we_hi, we_lo;
  logic [15:0] ram_rdata;

  responder_ram u_ram (
    .clk_i   (M68K_CLK),
    .addr_i  (ram_addr),
    .we_hi_i (we_hi),
    .we_lo_i (we_lo),
    .wdata_i (d_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    addr_d    = addr_q;
    rwc_d     = rwc_q;
    cnt_d     = cnt_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    vpa_n_d   = vpa_n_q;
    doe_d     = doe_q;
    dout_d    = dout_q;
    we_hi     = 1'b0;
    we_lo     = 1'b0;
    // In IDLE the live address feeds the RAM so read data is ready one edge after decode.
    ram_addr  = (state_q == IDLE) ? M68K_A[8:1] : addr_q;

    if (state_q != IDLE && as_q) begin
      state_d   = IDLE;
      dtack_n_d = 1'b1;
      berr_n_d  = 1'b1;
      vpa_n_d   = 1'b1;
      doe_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!as_q) begin
            addr_d  = M68K_A[8:1];
            rwc_d   = rw_q;
            state_d = WAIT;
            if (M68K_FC == FC_IACK) begin
              cls_d = CYC_VPA;
              cnt_d = 8'd0;
            end else if (M68K_A[23:9] == RAM_BASE) begin
              cls_d = CYC_RAM;
              cnt_d = WS_LOAD;
            end else if (M68K_A[23:16] == VPA_BASE) begin
              cls_d = CYC_VPA;
              cnt_d = 8'd0;
            end else begin
              cls_d = CYC_UNMAPPED;
              cnt_d = BT_LOAD;
            end
          end
        end
        WAIT: begin
          case (cls_q)
            CYC_RAM: begin
              if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
              end else if (rwc_q) begin
                dout_d    = ram_rdata;
                doe_d     = 1'b1;
                dtack_n_d = 1'b0;
                state_d   = ACK;
              end else if (!uds_q || !lds_q) begin
                we_hi     = !uds_q;
                we_lo     = !lds_q;
                dtack_n_d = 1'b0;
                state_d   = ACK;
              end
            end
            CYC_VPA: begin
              vpa_n_d = 1'b0;
              doe_d   = rwc_q;
              if (rwc_q) dout_d = 16'h0000;
              state_d = ACK;
            end
            default: begin
              if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
              end else begin
                berr_n_d = 1'b0;
                state_d  = ACK;
              end
            end
          endcase
        end
        ACK:     state_d = ACK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      as_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      rw_q      <= 1'b1;
      d_q       <= 16'h0000;
      state_q   <= IDLE;
      cls_q     <= CYC_UNMAPPED;
      addr_q    <= 8'h00;
      rwc_q     <= 1'b1;
      cnt_q     <= 8'h00;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      vpa_n_q   <= 1'b1;
      doe_q     <= 1'b0;
      dout_q    <= 16'h0000;
    end else begin
      as_q      <= M68K_AS_n;
      uds_q     <= M68K_UDS_n;
      lds_q     <= M68K_LDS_n;
      rw_q      <= M68K_RW;
      d_q       <= M68K_D_IN;
      state_q   <= state_d;
      cls_q     <= cls_d;
      addr_q    <= addr_d;
      rwc_q     <= rwc_d;
      cnt_q     <= cnt_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      vpa_n_q   <= vpa_n_d;
      doe_q     <= doe_d;
      dout_q    <= dout_d;
    end
  end

  assign M68K_D_OUT   = dout_q;
  assign M68K_D_OE    = doe_q;
  assign M68K_DTACK_n = dtack_n_q;
  assign M68K_BERR_n  = berr_n_q;
  assign M68K_VPA_n   = vpa_n_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench for m68k_bus_responder: a driver issues bus cycles and queues
// the expected response; a monitor pops and compares each response it observes.
module tb_m68k_bus_responder;

  localparam int          WS = 1;
  localparam int          BT = 8;
  localparam logic [14:0] RB = 15'h0000;
  localparam logic [7:0]  VB = 8'hBF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:1] a = '0;
  logic [2:0]  fc = 3'b101;
  logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        doe, dtack_n, berr_n, vpa_n;

  always #5 clk = ~clk;

  m68k_bus_responder #(
    .RAM_BASE(RB), .VPA_BASE(VB), .WAIT_STATES(WS), .BERR_TIMEOUT(BT)
  ) dut (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_D_IN(din), .M68K_D_OUT(dout), .M68K_D_OE(doe),
    .M68K_DTACK_n(dtack_n), .M68K_BERR_n(berr_n), .M68K_VPA_n(vpa_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [2:0]  strb;   // expected {DTACK_n, BERR_n, VPA_n}
    logic        oe;
    logic [15:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] mdl[256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1ns after each rising edge; the sample after edge n sees cyc == n.
  initial begin
    bit   prev_resp = 1'b0;
    bit   resp;
    logic prev_as = 1'b1;
    int   rel_at = -1;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      resp = (dtack_n === 1'b0) || (berr_n === 1'b0) || (vpa_n === 1'b0);
      if (rel_at == cyc)
        check("release", 32'({dtack_n, berr_n, vpa_n, doe}), 32'(4'b1110));
      if (prev_as === 1'b0 && as_n === 1'b1) rel_at = cyc + 1;
      prev_as = as_n;
      if (resp && !prev_resp) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: got strobes %b expected none (cycle %0d)",
                   {dtack_n, berr_n, vpa_n}, cyc);
        end else begin
          x = expq.pop_front();
          check("resp_edge", 32'(cyc), 32'(x.edge_n));
          check("strobes", 32'({dtack_n, berr_n, vpa_n}), 32'(x.strb));
          check("d_oe", 32'(doe), 32'(x.oe));
          if (x.oe) check("d_out", 32'(dout), 32'(x.data));
        end
      end else if (expq.size() > 0 && expq[0].edge_n <= cyc) begin
        x = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing: got no response expected strobes %b at cycle %0d", x.strb, x.edge_n);
      end
      prev_resp = resp;
    end
  end

  // One bus cycle. sd: strobe delay in cycles after AS; abort: AS rises at t0+abort
  // (0 = normal); rst_mid: pull reset while the response is asserted.
  task automatic bus(input logic [23:1] addr, input logic [2:0] f, input logic r,
                     input logic u, input logic l, input logic [15:0] wd,
                     input int sd, input int abort, input bit rst_mid);
    int          k, t0, e, rise;
    bit          is_ram, is_vpa;
    exp_t        x;
    logic [15:0] w;
    @(negedge clk);
    k  = cyc;
    t0 = k + 2;
    a = addr; fc = f; rw = r; din = wd; as_n = 1'b0;
    if (sd == 0) begin uds_n = u; lds_n = l; end
    is_ram = (f != 3'b111) && (addr[23:9] == RB);
    is_vpa = !is_ram && ((f == 3'b111) || (addr[23:16] == VB));
    if (is_ram) begin
      e = t0 + 1 + WS;
      if (!r && (k + sd + 2 > e)) e = k + sd + 2;
    end else if (is_vpa) e = t0 + 1;
    else e = t0 + 1 + BT;
    rise = (abort > 0) ? t0 + abort - 1 : e;
    if (e < rise + 2) begin
      x.edge_n = e;
      x.strb   = is_ram ? 3'b011 : (is_vpa ? 3'b110 : 3'b101);
      x.oe     = r && (is_ram || is_vpa);
      x.data   = is_ram ? mdl[addr[8:1]] : 16'h0000;
      expq.push_back(x);
      if (is_ram && !r) begin
        w = mdl[addr[8:1]];
        if (!u) w[15:8] = wd[15:8];
        if (!l) w[7:0]  = wd[7:0];
        mdl[addr[8:1]] = w;
      end
    end
    while (cyc < rise) begin
      @(negedge clk);
      if (sd > 0 && cyc == k + sd) begin uds_n = u; lds_n = l; end
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", 32'({dtack_n, berr_n, vpa_n, doe}), 32'(4'b1110));
      check("rst_mid_dout", 32'(dout), 32'h0);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    if (rst_mid) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    logic [23:1] ad;
    logic [2:0]  f;
    logic        r, u, l;
    int          sel, sd, ab;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({dtack_n, berr_n, vpa_n, doe}), 32'(4'b1110));
    check("reset_dout", 32'(dout), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 32'({dtack_n, berr_n, vpa_n, doe}), 32'(4'b1110));

    for (int i = 0; i < 256; i++)
      bus({RB, 8'(i)}, 3'b101, 1'b0, 1'b0, 1'b0, 16'($urandom), 0, 0, 1'b0);

    bus(23'h000010, 3'b101, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 0, 1'b0);
    bus(23'h000010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);
    bus(23'h000010, 3'b101, 1'b0, 1'b0, 1'b1, 16'h12FF, 3, 0, 1'b0);
    bus(23'h000010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);
    check("byte_lane_model", 32'(mdl[8'h10]), 32'h12EF);
    bus(23'h7FFFFF, 3'b111, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 0, 1'b0);
    bus(23'h200000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);
    bus(23'h200000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 1'b0);
    bus({VB, 15'h0010}, 3'b101, 1'b0, 1'b0, 1'b0, 16'h5555, 0, 0, 1'b0);
    bus(23'h000010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b1);
    bus(23'h000010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);
    bus(23'h000000, 3'b101, 1'b0, 1'b0, 1'b0, 16'hA001, 0, 0, 1'b0);
    bus(23'h0000FF, 3'b101, 1'b0, 1'b0, 1'b0, 16'h5FFE, 0, 0, 1'b0);
    bus(23'h000000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);
    bus(23'h0000FF, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      f   = 3'($urandom_range(0, 6));
      r   = 1'($urandom);
      u   = 1'($urandom);
      l   = r ? 1'b0 : (u ? 1'b0 : 1'($urandom));
      if (r) u = 1'b0;
      sd  = r ? 0 : int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0;
      if (sel < 6)      ad = {RB, 8'($urandom)};
      else if (sel < 8) ad = {VB, 15'($urandom)};
      else if (sel < 9) begin ad = {20'hFFFFF, 3'($urandom)}; f = 3'b111; end
      else              ad = {8'h40, 15'($urandom)};
      bus(ad, f, r, u, l, 16'($urandom), sd, ab, 1'b0);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
